// File: rtl/vram_port_arbiter_if.sv
// Bus bundle between the VRAM arbiter, its two requesters and the block RAM.
// The arbiter uses the slave view; the requesters and RAM model use master.
interface vram_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic                  vid_req;
  logic [ADDR_W-1:0]     vid_addr;
  logic                  vid_gnt;
  logic                  vid_rvalid;
  logic [DATA_W-1:0]     vid_rdata;

  logic                  host_valid;
  logic                  host_we;
  logic [ADDR_W-1:0]     host_addr;
  logic [DATA_W-1:0]     host_wdata;
  logic [DATA_W/8-1:0]   host_wstrb;
  logic                  host_ready;
  logic                  host_rvalid;
  logic [DATA_W-1:0]     host_rdata;

  logic                  bram_en;
  logic [DATA_W/8-1:0]   bram_we;
  logic [ADDR_W-1:0]     bram_addr;
  logic [DATA_W-1:0]     bram_din;
  logic [DATA_W-1:0]     bram_dout;

  modport slave (
    input  vid_req, vid_addr,
    input  host_valid, host_we, host_addr, host_wdata, host_wstrb,
    input  bram_dout,
    output vid_gnt, vid_rvalid, vid_rdata,
    output host_ready, host_rvalid, host_rdata,
    output bram_en, bram_we, bram_addr, bram_din
  );

  modport master (
    output vid_req, vid_addr,
    output host_valid, host_we, host_addr, host_wdata, host_wstrb,
    output bram_dout,
    input  vid_gnt, vid_rvalid, vid_rdata,
    input  host_ready, host_rvalid, host_rdata,
    input  bram_en, bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// Shares one single-port VRAM between video scan-out (fixed priority) and the
// host register path, with a starvation limit that forces a host grant.
module vram_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int DEPTH    = 601,
  parameter int MAX_WAIT = 4
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESETN,
  vram_port_arbiter_if.slave  bus,
  output logic [15:0]         forced_cnt
);

  localparam logic [7:0]  MAX_WAIT_L = 8'(MAX_WAIT);
  localparam logic [31:0] DEPTH_L    = 32'(DEPTH);

  logic [7:0]        wait_cnt;
  logic              force_grant;
  logic              any_gnt;
  logic              in_range;
  logic              host_wr;
  logic [ADDR_W-1:0] gnt_addr;
  logic              vid_pend;
  logic              host_pend;
  logic              oor_pend;

  assign force_grant    = bus.host_valid && (wait_cnt == MAX_WAIT_L);
  assign bus.host_ready = bus.host_valid && (!bus.vid_req || force_grant);
  assign bus.vid_gnt    = bus.vid_req && !bus.host_ready;
  assign any_gnt        = bus.host_ready || bus.vid_gnt;

  assign gnt_addr = bus.host_ready ? bus.host_addr : bus.vid_addr;
  assign in_range = {{(32-ADDR_W){1'b0}}, gnt_addr} < DEPTH_L;
  assign host_wr  = bus.host_ready && bus.host_we && in_range;

  // Out-of-range grants keep the RAM idle; addr/din stay 0 when nothing is granted.
  assign bus.bram_en   = any_gnt && in_range;
  assign bus.bram_addr = bus.bram_en ? gnt_addr : '0;
  assign bus.bram_we   = host_wr ? bus.host_wstrb : '0;
  assign bus.bram_din  = host_wr ? bus.host_wdata : '0;

  assign bus.vid_rvalid  = vid_pend;
  assign bus.host_rvalid = host_pend;
  assign bus.vid_rdata   = (vid_pend && !oor_pend) ? bus.bram_dout : '0;
  assign bus.host_rdata  = (host_pend && !oor_pend) ? bus.bram_dout : '0;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      vid_pend   <= 1'b0;
      host_pend  <= 1'b0;
      oor_pend   <= 1'b0;
      wait_cnt   <= '0;
      forced_cnt <= '0;
    end else begin
      vid_pend  <= bus.vid_gnt;
      host_pend <= bus.host_ready && !bus.host_we;
      // Only one grant per cycle, so a single out-of-range flag covers both owners.
      oor_pend  <= any_gnt && !in_range;

      if (!bus.host_valid || bus.host_ready)
        wait_cnt <= '0;
      else if (wait_cnt != MAX_WAIT_L)
        wait_cnt <= wait_cnt + 8'd1;

      if (force_grant && bus.vid_req && (forced_cnt != 16'hFFFF))
        forced_cnt <= forced_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Bench for vram_port_arbiter: a RAM model, directed scenarios and a random
// phase, all checked every cycle against a behavioural reference.
module tb_vram_port_arbiter;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 10;
  localparam int DEPTH    = 601;
  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] forced_cnt;
  int          n_checks = 0;
  int          n_err    = 0;

  vram_port_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  vram_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .bus          (bus),
    .forced_cnt   (forced_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE0000 ^ 32'(i * 66051);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Block RAM model, read-first, one cycle latency.
  logic [31:0] ram [0:1023];
  bit          ram_ready;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) ram[i] <= pat(i);
      ram_ready <= 1'b1;
    end else if (bus.bram_en) begin
      bus.bram_dout <= ram[bus.bram_addr];
      for (int b = 0; b < 4; b++)
        if (bus.bram_we[b]) ram[bus.bram_addr][8*b +: 8] <= bus.bram_din[8*b +: 8];
    end
  end

  // Reference model: golden word store, denied-cycle count and expected responses.
  logic [31:0] gold [0:1023];
  bit          gold_ready;
  int          m_wait, m_forced;
  logic        e_vrv, e_hrv, e_hr, e_vg, e_inr, e_hwr, e_frc;
  logic [31:0] e_vrd, e_hrd;
  logic [9:0]  e_ga;

  always @(negedge clk) begin
    if (!gold_ready) begin
      for (int i = 0; i < 1024; i++) gold[i] = pat(i);
      gold_ready = 1'b1;
    end
    if (!rst_n) begin
      m_wait = 0; m_forced = 0;
      e_vrv = 0; e_hrv = 0; e_vrd = 0; e_hrd = 0;
      chk("rst_vid_gnt",     32'(bus.vid_gnt),     0);
      chk("rst_host_ready",  32'(bus.host_ready),  0);
      chk("rst_bram_en",     32'(bus.bram_en),     0);
      chk("rst_vid_rvalid",  32'(bus.vid_rvalid),  0);
      chk("rst_host_rvalid", 32'(bus.host_rvalid), 0);
      chk("rst_rdata",       bus.vid_rdata | bus.host_rdata, 0);
      chk("rst_forced_cnt",  32'(forced_cnt),      0);
    end else begin
      e_frc = bus.host_valid && (m_wait == MAX_WAIT);
      e_hr  = bus.host_valid && (!bus.vid_req || e_frc);
      e_vg  = bus.vid_req && !e_hr;
      e_ga  = e_hr ? bus.host_addr : bus.vid_addr;
      e_inr = int'(e_ga) < DEPTH;
      e_hwr = e_hr && bus.host_we && e_inr;

      chk("host_ready",  32'(bus.host_ready),  32'(e_hr));
      chk("vid_gnt",     32'(bus.vid_gnt),     32'(e_vg));
      chk("bram_en",     32'(bus.bram_en),     32'((e_hr || e_vg) && e_inr));
      chk("bram_addr",   32'(bus.bram_addr),   ((e_hr || e_vg) && e_inr) ? 32'(e_ga) : 0);
      chk("bram_we",     32'(bus.bram_we),     e_hwr ? 32'(bus.host_wstrb) : 0);
      chk("bram_din",    bus.bram_din,         e_hwr ? bus.host_wdata : 0);
      chk("vid_rvalid",  32'(bus.vid_rvalid),  32'(e_vrv));
      chk("vid_rdata",   bus.vid_rdata,        e_vrd);
      chk("host_rvalid", 32'(bus.host_rvalid), 32'(e_hrv));
      chk("host_rdata",  bus.host_rdata,       e_hrd);
      chk("forced_cnt",  32'(forced_cnt),      32'(m_forced));

      e_vrv = e_vg;
      e_vrd = (e_vg && e_inr) ? gold[e_ga] : 0;
      e_hrv = e_hr && !bus.host_we;
      e_hrd = (e_hr && !bus.host_we && e_inr) ? gold[e_ga] : 0;
      if (e_hwr)
        for (int b = 0; b < 4; b++)
          if (bus.host_wstrb[b]) gold[e_ga][8*b +: 8] = bus.host_wdata[8*b +: 8];
      if (e_frc && bus.vid_req && m_forced < 65535) m_forced++;
      m_wait = (bus.host_valid && !e_hr) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One host transaction; returns at 1 ns after a rising edge.
  task automatic host_op(input logic we, input logic [9:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output int lat,
                         output logic vg_at, output logic en_at);
    bit ok;
    ok = 0; lat = 0; rd = '0; vg_at = 0; en_at = 0;
    bus.host_valid = 1; bus.host_we = we; bus.host_addr = a;
    bus.host_wdata = d; bus.host_wstrb = s;
    while (!ok && lat <= 50) begin
      @(negedge clk);
      if (bus.host_ready) begin
        ok = 1; vg_at = bus.vid_gnt; en_at = bus.bram_en;
      end else lat++;
      tick();
    end
    bus.host_valid = 0; bus.host_we = 0; bus.host_addr = '0;
    bus.host_wdata = '0; bus.host_wstrb = '0;
    if (!ok) begin
      n_checks++; n_err++;
      $display("FAIL host_timeout: got no host_ready, expected grant within 50 cycles");
    end else if (!we) begin
      @(negedge clk);
      rd = bus.host_rdata;
      tick();
    end
  endtask

  logic [31:0] rd;
  int          lat;
  logic        vg_at, en_at;

  initial begin
    rst_n = 0;
    bus.vid_req = 0; bus.vid_addr = '0;
    bus.host_valid = 0; bus.host_we = 0; bus.host_addr = '0;
    bus.host_wdata = '0; bus.host_wstrb = '0;
    repeat (3) tick();
    rst_n = 1;
    tick();
    @(negedge clk);
    chk("init_forced_cnt", 32'(forced_cnt), 0);
    tick();

    // Video saturating the port: host read granted on its 5th cycle.
    bus.vid_req = 1; bus.vid_addr = 10'd3;
    host_op(0, 10'd2, 0, 0, rd, lat, vg_at, en_at);
    chk("contention_latency", 32'(lat), 4);
    chk("contention_vid_gnt", 32'(vg_at), 0);
    chk("contention_rdata",   rd, pat(2));
    chk("contention_forced",  32'(forced_cnt), 1);
    bus.vid_req = 0;

    host_op(1, 10'd5, 32'hDEADBEEF, 4'hF, rd, lat, vg_at, en_at);
    chk("host_wr_latency", 32'(lat), 0);
    host_op(0, 10'd5, 0, 0, rd, lat, vg_at, en_at);
    chk("host_rd_latency", 32'(lat), 0);
    chk("host_rd_data",    rd, 32'hDEADBEEF);

    host_op(1, 10'd7, 32'h11223344, 4'hF, rd, lat, vg_at, en_at);
    host_op(1, 10'd7, 32'hAABBCCDD, 4'h2, rd, lat, vg_at, en_at);
    host_op(0, 10'd7, 0, 0, rd, lat, vg_at, en_at);
    chk("strobe_merge", rd, 32'h1122CC44);

    host_op(1, 10'd5, 32'h0BADF00D, 4'h0, rd, lat, vg_at, en_at);
    chk("zero_strb_en", 32'(en_at), 1);
    host_op(0, 10'd5, 0, 0, rd, lat, vg_at, en_at);
    chk("zero_strb_keep", rd, 32'hDEADBEEF);

    host_op(1, 10'd700, 32'hFFFFFFFF, 4'hF, rd, lat, vg_at, en_at);
    chk("oor_wr_en", 32'(en_at), 0);
    host_op(0, 10'd700, 0, 0, rd, lat, vg_at, en_at);
    chk("oor_rd_en",   32'(en_at), 0);
    chk("oor_rd_data", rd, 0);
    host_op(1, 10'd600, 32'h12345678, 4'hF, rd, lat, vg_at, en_at);
    host_op(0, 10'd600, 0, 0, rd, lat, vg_at, en_at);
    chk("ctrl_word", rd, 32'h12345678);

    // Video read then host read on consecutive cycles.
    bus.vid_req = 1; bus.vid_addr = 10'd0;
    tick();
    bus.vid_req = 0;
    bus.host_valid = 1; bus.host_we = 0; bus.host_addr = 10'd1;
    @(negedge clk);
    chk("ilv_vid_rvalid", 32'(bus.vid_rvalid), 1);
    chk("ilv_vid_rdata",  bus.vid_rdata, pat(0));
    chk("ilv_host_ready", 32'(bus.host_ready), 1);
    tick();
    bus.host_valid = 0; bus.host_addr = '0;
    @(negedge clk);
    chk("ilv_host_rvalid", 32'(bus.host_rvalid), 1);
    chk("ilv_host_rdata",  bus.host_rdata, pat(1));
    tick();

    // Reset the cycle after a host read grant: response must vanish.
    bus.host_valid = 1; bus.host_we = 0; bus.host_addr = 10'd5;
    tick();
    bus.host_valid = 0; bus.host_addr = '0;
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_rvalid", 32'(bus.vid_rvalid | bus.host_rvalid), 0);
      chk("post_rst_forced", 32'(forced_cnt), 0);
      chk("post_rst_bram_en", 32'(bus.bram_en), 0);
      tick();
    end

    // Random traffic checked cycle by cycle by the reference model.
    fork
      begin
        for (int i = 0; i < 1500; i++) begin
          bus.vid_req  = ($urandom_range(0, 9) < 7);
          bus.vid_addr = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(590, 1023))
                                                      : 10'($urandom_range(0, 15));
          tick();
        end
        bus.vid_req = 0; bus.vid_addr = '0;
      end
      begin
        logic [31:0] r_rd;
        int          r_lat;
        logic        r_vg, r_en;
        for (int j = 0; j < 300; j++) begin
          host_op(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 10'($urandom_range(595, 1023))
                                              : 10'($urandom_range(0, 15)),
                  $urandom, 4'($urandom_range(0, 15)), r_rd, r_lat, r_vg, r_en);
          repeat ($urandom_range(0, 2)) tick();
        end
      end
    join
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares one single-port VRAM block RAM (1-cycle read latency) between two requesters: the HDMI text scan-out fetch (video, read-only, latency-critical) and the host register path (AXI-lite write/read side).
- Video has fixed priority. A starvation counter forces a host grant after MAX_WAIT consecutive denied host cycles.
- Also handles out-of-range addresses and keeps a saturating count of forced host grants.

Parameters:
- DATA_W, 32, VRAM word width; byte strobes are DATA_W/8 bits.
- ADDR_W, 10, word-address width on all ports.
- DEPTH, 601, valid words 0..DEPTH-1 (600 glyph words plus the control word at 600).
- MAX_WAIT, 4, consecutive denied host cycles before the host is forced to win (1..255).

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- vid_req  in  1  video read request, single-cycle, may be asserted every cycle.
- vid_addr  in  ADDR_W  video word address.
- vid_gnt  out  1  video request accepted this cycle (combinational).
- vid_rvalid  out  1  video read data valid.
- vid_rdata  out  DATA_W  video read data.
- host_valid  in  1  host request; held with addr/we/wdata/wstrb stable until host_ready.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host word address.
- host_wdata  in  DATA_W  host write data.
- host_wstrb  in  DATA_W/8  host byte enables.
- host_ready  out  1  host request accepted this cycle (combinational).
- host_rvalid  out  1  host read data valid.
- host_rdata  out  DATA_W  host read data.
- bram_en  out  1  BRAM enable.
- bram_we  out  DATA_W/8  BRAM byte write enables.
- bram_addr  out  ADDR_W  BRAM address.
- bram_din  out  DATA_W  BRAM write data.
- bram_dout  in  DATA_W  BRAM read data, valid 1 cycle after an enabled read.
- forced_cnt  out  16  saturating count of starvation-forced host grants.

Behaviour:
- Reset (async assert, sync deassert by the system): wait_cnt=0, forced_cnt=0, pending-response flags clear. All outputs are 0 during and after reset until a request arrives.

Arbitration, evaluated combinationally each cycle:
- force = host_valid && wait_cnt==MAX_WAIT.
- host_ready = host_valid && (!vid_req || force).
- vid_gnt = vid_req && !host_ready.
- At most one grant per cycle; with no requests, no grant and bram_en=0.

BRAM drive:
- Granted request with in-range address (addr < DEPTH): bram_en=1, bram_addr=addr.
- Host write: bram_we=host_wstrb, bram_din=host_wdata. Reads: bram_we=0.
- Host write with wstrb=0: handshake completes, bram_en=1, bram_we=0, no data change, no rvalid.
- Out-of-range grant (addr >= DEPTH): bram_en=0. Writes are dropped. Reads still complete and return 0.

Read response, fixed 1-cycle latency, no backpressure (consumers must accept):
- Cycle after a granted video read: vid_rvalid=1, vid_rdata=bram_dout, or 0 if out of range.
- Cycle after a granted host read: host_rvalid=1, host_rdata=bram_dout, or 0 if out of range.
- Host writes produce no rvalid.
- rdata is 0 whenever its rvalid is 0.
- Pending flags (vid_pend, host_pend, oor_pend) are registered at grant.

Starvation counter wait_cnt (8 bit):
- Cleared on host_ready or when !host_valid.
- Otherwise increments, holding at MAX_WAIT.
- The forced grant happens in the cycle wait_cnt==MAX_WAIT. A host request blocked from its first cycle is therefore granted on its (MAX_WAIT+1)th cycle.

forced_cnt:
- Increments on every cycle where force && vid_req. Saturates at 0xFFFF.

Boundaries:
- Simultaneous requests with wait_cnt<MAX_WAIT: video wins.
- Back-to-back grants to alternating owners: responses return in grant order, one per cycle.
- Reset asserted with a read pending: the pending response is discarded and no rvalid is issued after reset.

Test Plan:
- Host-only: write addr 5 data 0xDEADBEEF wstrb 0xF, then read addr 5 -> host_ready same cycle as valid; host_rvalid 1 cycle after read grant, rdata 0xDEADBEEF.
- Byte strobes: write 0x11223344 to addr 7, then write 0xAABBCCDD wstrb 0x2 -> read returns 0x1122CC44.
- Contention: vid_req held high continuously, host read asserted at cycle 0 -> host_ready at cycle 4 (MAX_WAIT=4), vid_gnt=0 that cycle only, forced_cnt=1.
- Out of range: host write to addr 700 then read 700 -> bram_en=0 both times, host_rvalid with rdata 0; word 600 (control) remains writable/readable.
- Interleaving: vid read addr 0 at cycle t, host read addr 1 at t+1 (vid_req low) -> vid_rvalid at t+1, host_rvalid at t+2, each with the correct word.
- Async reset mid-read: pull S_AXI_ARESETN low the cycle after a grant -> no rvalid after release, forced_cnt=0, all outputs 0.
